ccd_line_axis: RTL

CCD_LINE_AXIS -- requirements
Module: ccd_line_axis

---
 rtl/ccd_line_axis.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/ccd_line_axis.sv
// CCD line framer: strips dummy columns, optionally bins pixel pairs 2:1, and
// streams the effective pixels as AXI4-Stream beats through a FWFT FIFO.
module ccd_line_axis #(
  parameter int DATA_WIDTH      = 12,
  parameter int EFFECT_COLS     = 2048,
  parameter int PRE_DUMMY_COLS  = 32,
  parameter int POST_DUMMY_COLS = 8,
  parameter int FIFO_DEPTH      = 64
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  input  logic                  line_start,
  input  logic [10:0]           rows,
  input  logic                  bin2,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  overflow
);

  localparam int TOTAL_COLS = PRE_DUMMY_COLS + EFFECT_COLS + POST_DUMMY_COLS;
  localparam int CW         = $clog2(TOTAL_COLS + 1);
  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int CNTW       = AW + 1;
  localparam int FW         = DATA_WIDTH + 2;

  localparam logic [CW-1:0] C_FIRST     = CW'(PRE_DUMMY_COLS);
  localparam logic [CW-1:0] C_FIRST_BIN = CW'(PRE_DUMMY_COLS + 1);
  localparam logic [CW-1:0] C_LAST      = CW'(PRE_DUMMY_COLS + EFFECT_COLS - 1);
  localparam logic [CW-1:0] C_END       = CW'(TOTAL_COLS - 1);

  function automatic logic [DATA_WIDTH-1:0] f_bin_avg(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return DATA_WIDTH'(sum >> 1);
  endfunction

  // line state
  logic                  r_active;
  logic [CW-1:0]         r_col;
  logic                  r_bin;
  logic [10:0]           r_rows;
  logic [10:0]           r_line;
  logic                  r_has;
  logic [DATA_WIDTH-1:0] r_pair_a;

  // beat pipeline
  logic                  r_vld_p1;
  logic                  r_last_p1;
  logic                  r_user_p1;
  logic [DATA_WIDTH-1:0] r_data_p1;

  // fifo
  logic [FW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CNTW-1:0]       r_count;
  logic                  r_ovf;

  logic                  w_active;
  logic [CW-1:0]         w_col;
  logic                  w_bin;
  logic                  w_has;
  logic [10:0]           w_rows;
  logic [10:0]           w_rows_eff;
  logic                  w_line_wrap;
  logic                  w_beat;
  logic                  w_keep;
  logic                  w_emit;
  logic                  w_first;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_data;

  logic                  w_nempty;
  logic                  w_full;
  logic                  w_rd;
  logic                  w_wr;
  logic                  w_ovf_set;
  logic [FW-1:0]         w_head;

  // stage p0: a line_start in the same cycle as pix_valid applies to that beat
  always_comb begin
    w_active    = r_active | line_start;
    w_col       = line_start ? '0 : r_col;
    w_bin       = line_start ? bin2 : r_bin;
    w_has       = line_start ? 1'b0 : r_has;
    w_rows      = line_start ? rows : r_rows;
    w_rows_eff  = (w_rows == '0) ? 11'd1 : w_rows;
    w_line_wrap = ({1'b0, r_line} + 12'd1) >= {1'b0, w_rows_eff};
    w_beat      = pix_valid & w_active;
    w_keep      = w_beat & (w_col >= C_FIRST) & (w_col <= C_LAST);
    w_emit      = w_keep & (~w_bin | w_has);
    w_first     = w_bin ? (w_col == C_FIRST_BIN) : (w_col == C_FIRST);
    w_last      = (w_col == C_LAST);
    w_data      = w_bin ? f_bin_avg(r_pair_a, pix_data) : pix_data;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active  <= 1'b0;
      r_col     <= '0;
      r_bin     <= 1'b0;
      r_rows    <= '0;
      r_line    <= '0;
      r_has     <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
      r_user_p1 <= 1'b0;
    end else begin
      if (line_start) begin
        r_bin  <= bin2;
        r_rows <= rows;
      end
      // the counter parks on the last post-dummy column until the next line_start
      if (w_beat) begin
        if (w_col == C_END) begin
          r_active <= 1'b0;
          r_col    <= w_col;
        end else begin
          r_active <= 1'b1;
          r_col    <= w_col + CW'(1);
        end
      end else if (line_start) begin
        r_active <= 1'b1;
        r_col    <= '0;
      end
      if (w_keep && w_bin) begin
        r_has <= ~w_has;
      end else if (line_start) begin
        r_has <= 1'b0;
      end
      if (w_emit && w_last) begin
        r_line <= w_line_wrap ? '0 : r_line + 11'd1;
      end
      // stage p1: generated beat waits one cycle before the fifo write
      r_vld_p1  <= w_emit;
      r_last_p1 <= w_emit & w_last;
      r_user_p1 <= w_emit & w_first & (r_line == '0);
    end
  end

  always_ff @(posedge sys_clk) begin
    r_data_p1 <= w_data;
    if (w_keep && w_bin && !w_has) begin
      r_pair_a <= pix_data;
    end
  end

  // stage p2: fifo write, first-word-fall-through read
  always_comb begin
    w_nempty  = (r_count != '0);
    w_full    = (r_count == CNTW'(FIFO_DEPTH));
    w_rd      = w_nempty & m_axis_tready;
    w_wr      = r_vld_p1 & (~w_full | w_rd);
    w_ovf_set = r_vld_p1 & w_full & ~w_rd;
    w_head    = r_mem[r_rd_ptr];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= {r_user_p1, r_last_p1, r_data_p1};
    end
  end

  // head entry is gated so stale memory never shows while the fifo is empty
  always_comb begin
    m_axis_tvalid = w_nempty;
    m_axis_tdata  = w_nempty ? w_head[DATA_WIDTH-1:0] : '0;
    m_axis_tlast  = w_nempty & w_head[DATA_WIDTH];
    m_axis_tuser  = w_nempty & w_head[DATA_WIDTH+1];
    overflow      = r_ovf;
  end

endmodule
